// File: rtl/hamming_encode_arbiter.sv
// Round-robin front end that time-shares one (7,4) Hamming encoder among NUM_REQ clients.
// One job at a time: accept, pulse the encoder, wait out its latency, return the codeword.
module hamming_encode_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned ENC_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_mode,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 enc_enable,
  output logic [3:0]           enc_data_in,
  output logic                 enc_mode,
  input  logic [6:0]           enc_data_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [6:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = SEL_W + 1;
  localparam int unsigned CNT_W = (ENC_LATENCY > 1) ? $clog2(ENC_LATENCY) : 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         data_q, data_d;
  logic               mode_q, mode_d;
  logic [SEL_W-1:0]   job_id_q, job_id_d;
  logic               enc_enable_q, enc_enable_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [6:0]         rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] valid_rot;
  logic [SEL_W-1:0]   grant_off;
  logic [SUM_W-1:0]   grant_sum;
  logic [SEL_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [3:0]         nib [NUM_REQ];

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    valid_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    grant_off = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (valid_rot[SEL_W'(k - 1)]) grant_off = SEL_W'(k - 1);
    end
    grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
    if (grant_sum >= SUM_W'(NUM_REQ)) grant_sum = grant_sum - SUM_W'(NUM_REQ);
    grant_idx = grant_sum[SEL_W-1:0];
    grant_vld = (state_q == S_IDLE) && (|req_valid);
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign nib[g]       = req_data[4*g +: 4];
    assign req_ready[g] = grant_vld && (grant_idx == SEL_W'(g));
  end

  // Job sequencing: accept, one-cycle start pulse, latency wait, response handshake.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    mode_d       = mode_q;
    job_id_d     = job_id_q;
    enc_enable_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          data_d       = nib[grant_idx];
          mode_d       = req_mode[grant_idx];
          job_id_d     = grant_idx;
          enc_enable_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(ENC_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = enc_data_out;
          rsp_id_d    = ID_W'(job_id_q);
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (job_id_q == LAST_IDX) ? '0 : job_id_q + SEL_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      mode_q       <= 1'b0;
      job_id_q     <= '0;
      enc_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      job_id_q     <= job_id_d;
      enc_enable_q <= enc_enable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
    end
  end

  assign enc_enable  = enc_enable_q;
  assign enc_data_in = data_q;
  assign enc_mode    = mode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_hamming_encode_arbiter.sv
// Bench for hamming_encode_arbiter: behavioural 5-cycle encoder, arbitration model and
// response scoreboard, plus directed timing checks.
module tb_hamming_encode_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int ENC_LATENCY = 5;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_mode;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 enc_enable;
  logic [3:0]           enc_data_in;
  logic                 enc_mode;
  logic [6:0]           enc_data_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [6:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  int n_pass = 0;
  int n_chk  = 0;

  hamming_encode_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ENC_LATENCY(ENC_LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_mode(req_mode), .req_ready(req_ready),
    .enc_enable(enc_enable), .enc_data_in(enc_data_in), .enc_mode(enc_mode),
    .enc_data_out(enc_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Codeword layout {d3,d2,d1,p4,d0,p2,p1}; even=1 gives even parity groups.
  function automatic logic [6:0] ham(input logic [3:0] d, input logic even);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    if (!even) begin
      p1 = ~p1; p2 = ~p2; p4 = ~p4;
    end
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Encoder model: samples enable, output valid for one cycle ENC_LATENCY edges later.
  logic [6:0] enc_pend;
  int         enc_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt      <= 0;
      enc_pend     <= '0;
      enc_data_out <= '0;
    end else begin
      enc_data_out <= '0;
      if (enc_enable) begin
        enc_cnt  <= 1;
        enc_pend <= ham(enc_data_in, enc_mode);
      end else if (enc_cnt != 0) begin
        if (enc_cnt == ENC_LATENCY - 1) begin
          enc_data_out <= enc_pend;
          enc_cnt      <= 0;
        end else begin
          enc_cnt <= enc_cnt + 1;
        end
      end
    end
  end

  // Arbitration model and scoreboard, sampled on the falling edge.
  logic [ID_W+6:0] exp_q [$];
  int              m_ptr  = 0;
  bit              m_busy = 1'b0;
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic [ID_W+6:0]    e;
    int                 g;
    bit                 found;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr  = 0;
      m_busy = 1'b0;
    end else begin
      exp_ready = '0;
      g         = 0;
      found     = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && req_valid[(m_ptr + k) % NUM_REQ]) begin
            g     = (m_ptr + k) % NUM_REQ;
            found = 1'b1;
          end
        end
        if (found) exp_ready[g] = 1'b1;
      end
      check("req_ready", req_ready, exp_ready);
      if (found) begin
        exp_q.push_back({ID_W'(g), ham(req_data[4*g +: 4], req_mode[g])});
        m_busy = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_id", rsp_id, e[ID_W+6:7]);
          check("sb_data", rsp_data, e[6:0]);
          m_ptr  = (int'(e[ID_W+6:7]) + 1) % NUM_REQ;
          m_busy = 1'b0;
        end
      end
    end
  end

  // Waits (bounded) for rsp_valid; returns negedge count since the call.
  task automatic wait_rsp(input string tag, output int cyc, output logic [6:0] d,
                          output logic [ID_W-1:0] id);
    bit seen = 1'b0;
    cyc = 0; d = '0; id = '0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1; cyc = c; d = rsp_data; id = rsp_id;
      end
    end
    if (!seen) check({tag, "_timeout"}, rsp_valid, 1);
  endtask

  task automatic single_job(input string tag, input int i, input logic [3:0] d,
                            input logic m, input logic [6:0] exp_code);
    int cyc; logic [6:0] rd; logic [ID_W-1:0] rid;
    req_data[4*i +: 4] = d; req_mode[i] = m; req_valid[i] = 1'b1;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    wait_rsp(tag, cyc, rd, rid);
    check({tag, "_lat"}, cyc, 7);
    check({tag, "_data"}, rd, exp_code);
    check({tag, "_id"}, rid, i);
    @(posedge clk); #1;
  endtask

  initial begin
    int en_cnt, en_at, rsp_at, cyc, n;
    logic [6:0] rd;
    logic [ID_W-1:0] rid;
    int ids [5];
    int ats [5];
    int nrsp;

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_mode = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_enc_enable", enc_enable, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_enc_data_in", enc_data_in, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single even-mode job with full timing profile.
    rsp_ready = 1'b1;
    req_data[3:0] = 4'b1011; req_mode[0] = 1'b1; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    en_cnt = 0; en_at = 0; rsp_at = 0; rd = '0; rid = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) check("t1_busy", busy, 1);
      if (enc_enable) begin en_cnt++; en_at = c; end
      if (rsp_valid && rsp_at == 0) begin rsp_at = c; rd = rsp_data; rid = rsp_id; end
    end
    check("t1_en_at", en_at, 1);
    check("t1_en_cnt", en_cnt, 1);
    check("t1_rsp_at", rsp_at, 7);
    check("t1_data", rd, 7'b1010101);
    check("t1_id", rid, 0);
    check("t1_idle", busy, 0);
    @(posedge clk); #1;

    // Odd mode on requester 2.
    single_job("t2a", 2, 4'b1011, 1'b0, 7'b1011110);
    single_job("t2b", 2, 4'b0000, 1'b0, 7'b0001011);

    // Backpressure: hold response for 10 cycles while another request waits.
    rsp_ready = 1'b0;
    req_data[7:4] = 4'b0110; req_mode[1] = 1'b1; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_data[15:12] = 4'hE; req_mode[3] = 1'b0; req_valid[3] = 1'b1;
    wait_rsp("bp", cyc, rd, rid);
    check("bp_lat", cyc, 7);
    check("bp_data", rd, 7'b0110011);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 7'b0110011);
      check("bp_hold_id", rsp_id, 1);
      check("bp_hold_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_last_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_released", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_rsp("bp2", cyc, rd, rid);
    check("bp2_data", rd, ham(4'hE, 1'b0));
    check("bp2_id", rid, 3);
    @(posedge clk); #1;

    // Hold: requester input churns while the job is in flight.
    req_data[3:0] = 4'b0101; req_mode[0] = 1'b1; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      req_data[3:0] = 4'($urandom);
      req_mode[0]   = 1'($urandom);
      @(negedge clk);
      check("hold_data_in", enc_data_in, 4'b0101);
      check("hold_mode", enc_mode, 1);
      @(posedge clk); #1;
    end
    wait_rsp("hold", cyc, rd, rid);
    check("hold_rsp_data", rd, 7'b0101101);
    @(posedge clk); #1;

    // Reset in the middle of WAIT abandons the job.
    req_data[3:0] = 4'b1100; req_mode[0] = 1'b1; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_enable", enc_enable, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_rsp_id", rsp_id, 0);
    check("mid_rst_data_in", enc_data_in, 0);
    check("mid_rst_mode", enc_mode, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("post_rst_no_rsp", n, 0);
    @(posedge clk); #1;

    // Round-robin with every requester valid and rsp_ready tied high.
    req_data = {4'h9, 4'h6, 4'hC, 4'h3}; req_mode = 4'b0101; req_valid = 4'hF;
    nrsp = 0;
    for (int c = 1; c <= 60 && nrsp < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) begin ids[nrsp] = int'(rsp_id); ats[nrsp] = c; nrsp++; end
    end
    check("rr_count", nrsp, 5);
    for (int k = 0; k < 5; k++) check("rr_id", ids[k], k % NUM_REQ);
    for (int k = 1; k < 5; k++) check("rr_spacing", ats[k] - ats[k-1], 8);
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", busy, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
